shm_req_arbiter: RTL and testbench



---
 rtl/shm_pkg.sv | 23 ++
 rtl/shm_rr_picker.sv | 38 +++
 rtl/shm_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_shm_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shm_pkg.sv
// Shared constants and enumerations for the shared-memory request arbiter.
package shm_pkg;

   localparam int SIZE        = 16;
   localparam int WORD_SIZE   = 16;
   localparam int PAGE_SIZE   = 4;
   localparam int PAGES_COUNT = SIZE - PAGE_SIZE;

   typedef enum logic [1:0] {
      ACT_READ  = 2'd0,
      ACT_WRITE = 2'd1,
      ACT_ALLOC = 2'd2,
      ACT_FREE  = 2'd3
   } shm_action_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } arb_state_e;

endpackage

// File: rtl/shm_rr_picker.sv
// Rotating-priority encoder: returns the first pending index at or after rr_ptr,
// wrapping modulo PROC_CNT (valid for non-power-of-two requester counts).
module shm_rr_picker #(
   parameter int PROC_CNT = 4,
   localparam int IDX_W = $clog2(PROC_CNT)
) (
   input  logic [PROC_CNT-1:0] pending,
   input  logic [IDX_W-1:0]    rr_ptr,
   output logic [IDX_W-1:0]    grant,
   output logic                any_pending
);
   import shm_pkg::*;

   logic [IDX_W:0]   sum  [PROC_CNT];
   logic [IDX_W-1:0] cand [PROC_CNT];

   // cand[k] is the requester holding the k-th highest priority this cycle.
   generate
      for (genvar gi = 0; gi < PROC_CNT; gi++) begin : g_cand
         assign sum[gi]  = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
         assign cand[gi] = (sum[gi] >= (IDX_W+1)'(PROC_CNT))
                           ? IDX_W'(sum[gi] - (IDX_W+1)'(PROC_CNT))
                           : sum[gi][IDX_W-1:0];
      end
   endgenerate

   always_comb begin
      grant       = '0;
      any_pending = 1'b0;
      for (int k = PROC_CNT - 1; k >= 0; k--) begin
         if (pending[cand[k]]) begin
            grant       = cand[k];
            any_pending = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shm_req_arbiter.sv
// Round-robin arbiter sharing one shared-memory core among toggle-handshake requesters.
// Optional watchdog on the core response is enabled with `define SHM_ARB_TIMEOUT_EN.
module shm_req_arbiter #(
   parameter int PROC_CNT  = 4,
   parameter int SIZE      = shm_pkg::SIZE,
   parameter int WORD_SIZE = shm_pkg::WORD_SIZE,
   parameter int PAGE_SIZE = shm_pkg::PAGE_SIZE,
`ifdef SHM_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 64,
`endif
   localparam int PAGES_COUNT = SIZE - PAGE_SIZE,
   localparam int IDX_W = $clog2(PROC_CNT)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [0:PROC_CNT-1]    trigger,
   output logic [0:PROC_CNT-1]    ack,
   input  logic [1:0]             action   [0:PROC_CNT-1],
   input  logic [PAGES_COUNT-1:0] ptr      [0:PROC_CNT-1],
   input  logic [SIZE-1:0]        shift    [0:PROC_CNT-1],
   input  logic [WORD_SIZE-1:0]   data_in  [0:PROC_CNT-1],
   output logic [WORD_SIZE-1:0]   data_out [0:PROC_CNT-1],
   output logic [PAGES_COUNT-1:0] ptr_out  [0:PROC_CNT-1],
   output logic [0:PROC_CNT-1]    err,
   output logic                   core_req,
   output logic [1:0]             core_action,
   output logic [PAGES_COUNT-1:0] core_ptr,
   output logic [SIZE-1:0]        core_shift,
   output logic [WORD_SIZE-1:0]   core_data,
   input  logic                   core_done,
   input  logic [WORD_SIZE-1:0]   core_rdata,
   input  logic [PAGES_COUNT-1:0] core_rptr
);
   import shm_pkg::*;

   arb_state_e             state_reg, state_next;
   logic [IDX_W-1:0]       grant_reg, rr_ptr_reg, pick;
   logic [0:PROC_CNT-1]    last_trig_reg;
   logic [PROC_CNT-1:0]    pending;
   logic                   any_pending;
   logic [WORD_SIZE-1:0]   rdata_reg;
   logic [PAGES_COUNT-1:0] rptr_reg;
   logic                   expired;
   logic                   timed_out;

   generate
      for (genvar gi = 0; gi < PROC_CNT; gi++) begin : g_pend
         assign pending[gi] = trigger[gi] ^ last_trig_reg[gi];
      end
   endgenerate

   shm_rr_picker #(.PROC_CNT(PROC_CNT)) u_picker (
      .pending     (pending),
      .rr_ptr      (rr_ptr_reg),
      .grant       (pick),
      .any_pending (any_pending)
   );

`ifdef SHM_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_reg;
   logic            timed_out_reg;

   assign expired   = (state_reg == WAIT) && !core_done &&
                      (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
   assign timed_out = timed_out_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_reg    <= '0;
         timed_out_reg <= 1'b0;
         err           <= '0;
      end else begin
         unique case (state_reg)
            ISSUE: begin
               to_cnt_reg    <= '0;
               timed_out_reg <= 1'b0;
            end
            WAIT: begin
               to_cnt_reg <= to_cnt_reg + 1'b1;
               if (expired) timed_out_reg <= 1'b1;
            end
            RESPOND: err[grant_reg] <= timed_out_reg;
            default: ;
         endcase
      end
   end
`else
   assign expired   = 1'b0;
   assign timed_out = 1'b0;
   assign err       = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (any_pending) state_next = ISSUE;
         ISSUE:   state_next = core_done ? RESPOND : WAIT;
         WAIT:    if (core_done || expired) state_next = RESPOND;
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_req      <= 1'b0;
         core_action   <= '0;
         core_ptr      <= '0;
         core_shift    <= '0;
         core_data     <= '0;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         last_trig_reg <= '0;
         ack           <= '0;
         rdata_reg     <= '0;
         rptr_reg      <= '0;
         for (int i = 0; i < PROC_CNT; i++) begin
            data_out[i] <= '0;
            ptr_out[i]  <= '0;
         end
      end else begin
         core_req <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               if (any_pending) begin
                  grant_reg   <= pick;
                  core_req    <= 1'b1;
                  core_action <= action[pick];
                  core_ptr    <= ptr[pick];
                  core_shift  <= shift[pick];
                  core_data   <= data_in[pick];
               end
            end
            // Core results are only guaranteed alongside the done pulse.
            ISSUE, WAIT: begin
               if (core_done) begin
                  rdata_reg <= core_rdata;
                  rptr_reg  <= core_rptr;
               end
            end
            RESPOND: begin
               if (!timed_out && core_action == ACT_READ)  data_out[grant_reg] <= rdata_reg;
               if (!timed_out && core_action == ACT_ALLOC) ptr_out[grant_reg]  <= rptr_reg;
               ack[grant_reg]           <= ~ack[grant_reg];
               last_trig_reg[grant_reg] <= trigger[grant_reg];
               rr_ptr_reg <= (grant_reg == IDX_W'(PROC_CNT - 1)) ? '0 : grant_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shm_req_arbiter.sv
// Self-checking bench for shm_req_arbiter: directed scenarios plus random rounds
// checked against a round-robin service model and a behavioural core responder.
module tb_shm_req_arbiter;

   localparam int N     = 4;
   localparam int SZ    = 16;
   localparam int WS    = 16;
   localparam int PC    = 12;
   localparam int NEVER = 1000;
   localparam int LOGN  = 512;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic [0:N-1]   trigger, ack, err;
   logic [1:0]     action   [0:N-1];
   logic [PC-1:0]  ptr      [0:N-1];
   logic [SZ-1:0]  shift    [0:N-1];
   logic [WS-1:0]  data_in  [0:N-1];
   logic [WS-1:0]  data_out [0:N-1];
   logic [PC-1:0]  ptr_out  [0:N-1];
   logic           core_req, core_done;
   logic [1:0]     core_action;
   logic [PC-1:0]  core_ptr, core_rptr;
   logic [SZ-1:0]  core_shift;
   logic [WS-1:0]  core_data, core_rdata;

   int tests = 0;
   int fails = 0;

   // core command log and scripted responses, indexed by command number
   int            cmd_n = 0;
   logic [1:0]    log_act   [LOGN];
   logic [PC-1:0] log_ptr   [LOGN];
   logic [SZ-1:0] log_shift [LOGN];
   logic [WS-1:0] log_data  [LOGN];
   int            resp_delay [LOGN];
   logic [WS-1:0] resp_rdata [LOGN];
   logic [PC-1:0] resp_rptr  [LOGN];

   // reference model of what every requester should observe
   logic [0:N-1]  m_ack, m_last, m_err;
   logic [WS-1:0] m_data [N];
   logic [PC-1:0] m_ptr  [N];
   int            rr;

   shm_req_arbiter #(
      .PROC_CNT(N), .SIZE(SZ), .WORD_SIZE(WS), .PAGE_SIZE(4)
`ifdef SHM_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clock(clock), .reset_n(reset_n), .trigger(trigger), .ack(ack),
      .action(action), .ptr(ptr), .shift(shift), .data_in(data_in),
      .data_out(data_out), .ptr_out(ptr_out), .err(err),
      .core_req(core_req), .core_action(core_action), .core_ptr(core_ptr),
      .core_shift(core_shift), .core_data(core_data), .core_done(core_done),
      .core_rdata(core_rdata), .core_rptr(core_rptr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // core responder: logs each command, answers after resp_delay cycles
   initial begin
      int n, d;
      bit abort;
      core_done  = 1'b0;
      core_rdata = '0;
      core_rptr  = '0;
      forever begin
         @(posedge clock); #1;
         if (reset_n && core_req && cmd_n < LOGN) begin
            n = cmd_n;
            log_act[n] = core_action; log_ptr[n] = core_ptr;
            log_shift[n] = core_shift; log_data[n] = core_data;
            cmd_n++;
            d = resp_delay[n];
            core_rdata = resp_rdata[n];
            core_rptr  = resp_rptr[n];
            if (d == 0) core_done = 1'b1;
            @(posedge clock); #1;
            chk("req_pulse", {31'd0, core_req}, 32'd0);
            core_done = 1'b0;
            if (d > 0 && d < NEVER) begin
               abort = !reset_n;
               for (int k = 1; k < d && !abort; k++) begin
                  @(posedge clock); #1;
                  if (!reset_n) abort = 1;
               end
               if (!abort) begin
                  core_done = 1'b1;
                  @(posedge clock); #1;
                  core_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic model_reset();
      m_ack = '0; m_last = '0; m_err = '0; rr = 0;
      for (int i = 0; i < N; i++) begin m_data[i] = '0; m_ptr[i] = '0; end
   endtask

   task automatic set_req(input int i, input logic [1:0] a, input logic [PC-1:0] p,
                          input logic [SZ-1:0] s, input logic [WS-1:0] d);
      action[i] = a; ptr[i] = p; shift[i] = s; data_in[i] = d;
   endtask

   task automatic prep_resp();
      for (int k = 0; k < N; k++) begin
         resp_delay[cmd_n + k] = $urandom_range(0, 4);
         resp_rdata[cmd_n + k] = WS'($urandom);
         resp_rptr[cmd_n + k]  = PC'($urandom);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #2;
      reset_n = 1'b0;
      trigger = '0;
      @(posedge clock); @(posedge clock); #3;
      reset_n = 1'b1;
      model_reset();
      @(posedge clock); #1;
   endtask

   // toggle the requesters in tmask, then check the complete service round
   task automatic serve(input logic [N-1:0] tmask);
      int n0, idx, n, cnt;
      int order[$];
      logic [0:N-1] pend;
      bit to, done_ok;
      n0 = cmd_n;
      for (int i = 0; i < N; i++) if (tmask[i]) trigger[i] = ~trigger[i];
      pend = trigger ^ m_last;
      for (int k = 0; k < N; k++) begin
         idx = (rr + k) % N;
         if (pend[idx]) order.push_back(idx);
      end
      cnt = order.size();
      for (int k = 0; k < cnt; k++) begin
         idx = order[k];
         n = n0 + k;
         to = (resp_delay[n] >= NEVER);
         m_ack[idx] = ~m_ack[idx];
         m_last[idx] = trigger[idx];
         m_err[idx] = to;
         if (!to && action[idx] == shm_pkg::ACT_READ)  m_data[idx] = resp_rdata[n];
         if (!to && action[idx] == shm_pkg::ACT_ALLOC) m_ptr[idx]  = resp_rptr[n];
         rr = (idx + 1) % N;
      end
      done_ok = 0;
      for (int c = 0; c < 600; c++) begin
         if (ack === m_ack && cmd_n == n0 + cnt) begin done_ok = 1; break; end
         @(posedge clock); #1;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("serve_done", {31'd0, done_ok}, 32'd1);
      chk("cmd_count", cmd_n, n0 + cnt);
      for (int k = 0; k < cnt && n0 + k < cmd_n; k++) begin
         idx = order[k];
         chk($sformatf("cmd%0d_shift", k), {16'd0, log_shift[n0+k]}, {16'd0, shift[idx]});
         chk($sformatf("cmd%0d_action", k), {30'd0, log_act[n0+k]}, {30'd0, action[idx]});
         chk($sformatf("cmd%0d_ptr", k), {20'd0, log_ptr[n0+k]}, {20'd0, ptr[idx]});
         chk($sformatf("cmd%0d_data", k), {16'd0, log_data[n0+k]}, {16'd0, data_in[idx]});
      end
      for (int i = 0; i < N; i++) begin
         chk($sformatf("ack[%0d]", i), {31'd0, ack[i]}, {31'd0, m_ack[i]});
         chk($sformatf("err[%0d]", i), {31'd0, err[i]}, {31'd0, m_err[i]});
         chk($sformatf("data_out[%0d]", i), {16'd0, data_out[i]}, {16'd0, m_data[i]});
         chk($sformatf("ptr_out[%0d]", i), {20'd0, ptr_out[i]}, {20'd0, m_ptr[i]});
      end
      $display("[TB] round mask=%b served=%0d cmds=%0d", tmask, cnt, cmd_n - n0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] rmask;
      int n0;
      bit seen;
      trigger = '0;
      for (int i = 0; i < N; i++) set_req(i, 2'd0, '0, '0, '0);
      model_reset();
      repeat (3) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;

      // reset state
      chk("rst_core_req", {31'd0, core_req}, 32'd0);
      chk("rst_core_fields", {core_action, core_shift, core_ptr}, 32'd0);
      chk("rst_core_data", {16'd0, core_data}, 32'd0);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_ack[%0d]", i), {31'd0, ack[i]}, 32'd0);
         chk($sformatf("rst_err[%0d]", i), {31'd0, err[i]}, 32'd0);
         chk($sformatf("rst_data_out[%0d]", i), {16'd0, data_out[i]}, 32'd0);
         chk($sformatf("rst_ptr_out[%0d]", i), {20'd0, ptr_out[i]}, 32'd0);
      end

      // READ from requester 2, core answers in the ISSUE cycle
      set_req(2, shm_pkg::ACT_READ, 12'h003, 16'd5, 16'h1234);
      prep_resp();
      resp_delay[cmd_n] = 0;
      resp_rdata[cmd_n] = 16'hBEEF;
      serve(4'b0100);

      // all four at once from rr_ptr = 0, then requester 0 again
      do_reset();
      for (int i = 0; i < N; i++)
         set_req(i, shm_pkg::ACT_READ, PC'(i + 1), SZ'((i << 12) | 16'h0AA), WS'(16'h1000 + i));
      prep_resp();
      serve(4'b1111);
      set_req(0, shm_pkg::ACT_WRITE, 12'h055, 16'h0777, 16'hCAFE);
      prep_resp();
      serve(4'b0001);

      // ALLOC from requester 1
      set_req(1, shm_pkg::ACT_ALLOC, 12'h000, 16'h1010, 16'h0000);
      prep_resp();
      resp_rptr[cmd_n] = 12'd7;
      serve(4'b0010);

      // requester 0 toggles twice while requester 1 is in service
      set_req(1, shm_pkg::ACT_READ, 12'h011, 16'h1020, 16'h0000);
      prep_resp();
      resp_delay[cmd_n] = 6;
      fork
         serve(4'b0010);
         begin
            repeat (3) @(posedge clock);
            #1 trigger[0] = ~trigger[0];
            @(posedge clock);
            #1 trigger[0] = ~trigger[0];
         end
      join

      // reset during WAIT abandons the command; the raised trigger is served again
      do_reset();
      set_req(2, shm_pkg::ACT_WRITE, 12'h0F0, 16'h2468, 16'h5A5A);
      prep_resp();
      resp_delay[cmd_n] = 40;
      n0 = cmd_n;
      trigger[2] = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (cmd_n == n0 + 1) begin seen = 1; break; end
         @(posedge clock); #1;
      end
      chk("rst_wait_grant", {31'd0, seen}, 32'd1);
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_core_req", {31'd0, core_req}, 32'd0);
      chk("midrst_ack", {28'd0, ack}, 32'd0);
      chk("midrst_err", {28'd0, err}, 32'd0);
      @(posedge clock); @(posedge clock); #3;
      reset_n = 1'b1;
      model_reset();
      prep_resp();
      serve(4'b0000);

`ifdef SHM_ARB_TIMEOUT_EN
      // core never answers: watchdog completes the handshake with err set
      set_req(3, shm_pkg::ACT_READ, 12'h033, 16'h3003, 16'h0000);
      prep_resp();
      resp_delay[cmd_n] = NEVER;
      serve(4'b1000);
      set_req(3, shm_pkg::ACT_READ, 12'h034, 16'h3004, 16'h0000);
      prep_resp();
      serve(4'b1000);
`endif

      // random rounds
      for (int r = 0; r < 25; r++) begin
         rmask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++)
            if (rmask[i])
               set_req(i, 2'($urandom), PC'($urandom),
                       SZ'((i << 12) | $urandom_range(0, 4095)), WS'($urandom));
         prep_resp();
         serve(rmask);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
